// File: rtl/nn_param_streamer_if.sv
// Signal bundle between the host/config side, nn_param_streamer and the
// perceptron network byte interface.
interface nn_param_streamer_if;
   // Strobe semantics, no back-pressure: start is a 1-cycle request honoured
   // only when idle, and cfg_we is a 1-cycle write accepted only while not busy.
   // Anything presented at another time is dropped, never queued.
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        start;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [7:0]  net_data;
   logic        net_change;
   logic [1:0]  net_sel;
   logic [7:0]  net_result;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start, net_result,
      input  busy, done, result, net_data, net_change, net_sel
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start, net_result,
      output busy, done, result, net_data, net_change, net_sel
   );
endinterface

// File: rtl/nn_param_streamer.sv
// Streams buffered parameter/input bytes into the 4-neuron network and reads
// back its outputs. Optional feature macro: NN_STREAM_SKIP_EN (skip unchanged params).
module nn_param_streamer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic                clk,
   input  logic                reset,
   nn_param_streamer_if.slave  bus,
   output logic [3:0]          dbg_state_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_PARAM, S_ADV1, S_INPUT, S_ADV2, S_SETTLE,
      S_READ, S_ADV3, S_GAP, S_ADV4, S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] result_q, result_d;
   logic [7:0]  buf_q [28];
   logic        cfg_ok;

   // Buffer is writable only while the network is not being driven.
   assign cfg_ok = bus.cfg_we && (bus.cfg_addr < 5'd28) &&
                   ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef NN_STREAM_SKIP_EN
   logic param_wr;
   logic dirty_q, dirty_d;

   assign param_wr = cfg_ok && (bus.cfg_addr < 5'd24);

   always_comb begin
      dirty_d = dirty_q;
      if (state_q == S_DONE) dirty_d = 1'b0;
      if (param_wr)          dirty_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) dirty_q <= 1'b1;
      else       dirty_q <= dirty_d;
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               cnt_d = 5'd0;
`ifdef NN_STREAM_SKIP_EN
               // A same-cycle param write counts, since it lands before the run.
               state_d = (dirty_q || param_wr) ? S_PARAM : S_ADV1;
`else
               state_d = S_PARAM;
`endif
            end
         end
         S_PARAM: begin
            if (cnt_q == 5'd23) begin
               state_d = S_ADV1;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_ADV1: begin
            state_d = S_INPUT;
            cnt_d   = 5'd0;
         end
         S_INPUT: begin
            if (cnt_q == 5'd3) begin
               state_d = S_ADV2;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_ADV2: begin
            state_d = S_SETTLE;
            cnt_d   = 5'd0;
         end
         S_SETTLE: begin
            if (cnt_q == 5'(SETTLE_CYC - 1)) begin
               state_d = S_READ;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_READ: begin
            // Odd count is the second cycle of a neuron slot: selector has settled.
            if (cnt_q[0]) acc_d[{cnt_q[2:1], 3'b000} +: 8] = bus.net_result;
            if (cnt_q == 5'd7) begin
               state_d = S_ADV3;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_ADV3: state_d = S_GAP;
         S_GAP:  state_d = S_ADV4;
         S_ADV4: begin
            state_d  = S_DONE;
            result_d = acc_q;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         acc_q    <= 32'd0;
         result_q <= 32'd0;
         for (int i = 0; i < 28; i++) buf_q[i] <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         if (cfg_ok) buf_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   always_comb begin
      bus.net_data = 8'd0;
      bus.net_sel  = 2'd0;
      case (state_q)
         S_PARAM: bus.net_data = buf_q[cnt_q];
         S_INPUT: bus.net_data = buf_q[5'd24 + cnt_q];
         S_READ:  bus.net_sel  = cnt_q[2:1];
         default: ;
      endcase
   end

   assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.net_change = (state_q == S_ADV1) || (state_q == S_ADV2) ||
                           (state_q == S_ADV3) || (state_q == S_ADV4);
   assign bus.result     = result_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_nn_param_streamer.sv
// Bench for nn_param_streamer: randomized runs against a cycle-indexed
// expectation model; follows NN_STREAM_SKIP_EN when defined.
module tb_nn_param_streamer;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dbg_state;
  logic [7:0] net_base [4];

  always #5 clk = ~clk;

  nn_param_streamer_if bus();

  nn_param_streamer #(.SETTLE_CYC(S)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // Network output model: a fixed byte per selected neuron.
  assign bus.net_result = net_base[bus.net_sel];

  int checks = 0;
  int errors = 0;
  logic [7:0]  shadow [28];
  bit          dirty;
  logic [31:0] last_result;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 28; i++) shadow[i] = 8'd0;
    dirty = 1'b1;
    last_result = 32'd0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [4:0] a, input logic [7:0] d);
    if (a < 5'd28) shadow[a] = d;
    if (a < 5'd24) dirty = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   {31'd0, bus.busy},       32'd0);
    check({tag, "_done"},   {31'd0, bus.done},       32'd0);
    check({tag, "_data"},   {24'd0, bus.net_data},   32'd0);
    check({tag, "_chg"},    {31'd0, bus.net_change}, 32'd0);
    check({tag, "_sel"},    {30'd0, bus.net_sel},    32'd0);
    check({tag, "_result"}, bus.result,              last_result);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 5'd0;
    bus.cfg_data = 8'd0;
    clear_model();
    tick();
    tick();
    @(negedge clk);
    check_idle("rst");
    reset = 1'b0;
    tick();
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    model_write(a, d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // One inference started at cycle 0; each later cycle c is mapped onto the
  // full-length timeline p and checked against the protocol's event times.
  task automatic run(input bit wr, input logic [4:0] wa, input logic [7:0] wd, input bit noise);
    int off, len, r, p;
    logic [7:0]  e_data;
    logic [1:0]  e_sel;
    logic        e_chg, e_busy, e_done;
    logic [31:0] exp_res;
    bit full;
    bus.start = 1'b1;
    if (wr) begin
      bus.cfg_we = 1'b1;
      bus.cfg_addr = wa;
      bus.cfg_data = wd;
      model_write(wa, wd);
    end
`ifdef NN_STREAM_SKIP_EN
    full = dirty;
`else
    full = 1'b1;
`endif
    off = full ? 0 : 24;
    r = 31 + S;
    len = r + 11 - off;
    exp_q.push_back({net_base[3], net_base[2], net_base[1], net_base[0]});
    tick();
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c == len) begin
        bus.start = 1'b1;
        bus.cfg_we = 1'b0;
      end else if (noise) begin
        bus.start = ($urandom_range(0, 7) == 0);
        bus.cfg_we = ($urandom_range(0, 3) == 0);
        bus.cfg_addr = 5'($urandom_range(0, 31));
        bus.cfg_data = 8'($urandom);
      end
      p = c + off;
      e_data = 8'd0; e_sel = 2'd0; e_chg = 1'b0; e_busy = 1'b1; e_done = 1'b0;
      if (p <= 24) e_data = shadow[p - 1];
      else if (p == 25) e_chg = 1'b1;
      else if (p <= 29) e_data = shadow[p - 2];
      else if (p == 30) e_chg = 1'b1;
      else if (p >= r && p < r + 8) e_sel = 2'((p - r) / 2);
      else if (p == r + 8 || p == r + 10) e_chg = 1'b1;
      else if (p == r + 11) begin e_busy = 1'b0; e_done = 1'b1; end
      @(negedge clk);
      check($sformatf("data_c%0d", c), {24'd0, bus.net_data},   {24'd0, e_data});
      check($sformatf("chg_c%0d", c),  {31'd0, bus.net_change}, {31'd0, e_chg});
      check($sformatf("sel_c%0d", c),  {30'd0, bus.net_sel},    {30'd0, e_sel});
      check($sformatf("busy_c%0d", c), {31'd0, bus.busy},       {31'd0, e_busy});
      check($sformatf("done_c%0d", c), {31'd0, bus.done},       {31'd0, e_done});
      if (e_done) begin
        exp_res = exp_q.pop_front();
        check("result_done", bus.result, exp_res);
        last_result = exp_res;
      end else begin
        check($sformatf("result_hold_c%0d", c), bus.result, last_result);
      end
      tick();
    end
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    dirty = 1'b0;
    @(negedge clk);
    check_idle("post_run");
    tick();
  endtask

  task automatic rand_bases();
    for (int k = 0; k < 4; k++) net_base[k] = 8'($urandom);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) net_base[k] = 8'd0;
    do_reset();

    // Cleared buffer: zero bytes streamed, readback of random network outputs.
    rand_bases();
    run(1'b0, 5'd0, 8'd0, 1'b0);

    // Address-ordered pattern, then ignored starts/writes during the run.
    for (int a = 0; a < 28; a++) cfg_write(5'(a), 8'(a + 1));
    for (int k = 0; k < 4; k++) net_base[k] = 8'hA0 + 8'(k);
    run(1'b0, 5'd0, 8'd0, 1'b1);
    rand_bases();
    run(1'b0, 5'd0, 8'd0, 1'b1);

    // Write and start in the same cycle: write lands first.
    rand_bases();
    run(1'b1, 5'd5, 8'($urandom), 1'b0);

    // Randomized batches of idle writes (some to inputs only, some ignored).
    for (int n = 0; n < 4; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        if (n[0]) cfg_write(5'($urandom_range(24, 31)), 8'($urandom));
        else      cfg_write(5'($urandom_range(0, 31)), 8'($urandom));
      end
      rand_bases();
      run(1'b0, 5'd0, 8'd0, 1'($urandom_range(0, 1)));
    end

    // Reset asserted at cycle 27 of a run.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 27; c++) tick();
    reset = 1'b1;
    tick();
    clear_model();
    @(negedge clk);
    check_idle("midrst");
    reset = 1'b0;
    tick();
    rand_bases();
    run(1'b0, 5'd0, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
